// File: rtl/branch_resolve_bht_if.sv
// Fetch-prediction and EXE branch-resolution bundle for branch_resolve_bht.
// The master side is the pipeline; the slave side is the resolve unit.
interface branch_resolve_bht_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] pc_fetch;
  logic            pred_taken_fetch;
  logic            valid_exe;
  logic            stall_exe;
  logic            branch_exe;
  logic            jump_exe;
  logic [2:0]      funct3_exe;
  logic [XLEN-1:0] rs1_exe;
  logic [XLEN-1:0] rs2_exe;
  logic [XLEN-1:0] pc_exe;
  logic [XLEN-1:0] target_exe;
  logic            pred_taken_exe;
  logic            pc_src_exe;
  logic [XLEN-1:0] redirect_pc_exe;
  logic            mispredict_exe;
  logic            illegal_br_exe;

  modport master (
    output pc_fetch, valid_exe, stall_exe,
    output branch_exe, jump_exe, funct3_exe,
    output rs1_exe, rs2_exe, pc_exe,
    output target_exe, pred_taken_exe,
    input  pred_taken_fetch, pc_src_exe,
    input  redirect_pc_exe, mispredict_exe,
    input  illegal_br_exe
  );

  modport slave (
    input  pc_fetch, valid_exe, stall_exe,
    input  branch_exe, jump_exe, funct3_exe,
    input  rs1_exe, rs2_exe, pc_exe,
    input  target_exe, pred_taken_exe,
    output pred_taken_fetch, pc_src_exe,
    output redirect_pc_exe, mispredict_exe,
    output illegal_br_exe
  );
endinterface

// File: rtl/branch_resolve_bht.sv
// EXE branch resolution with a bimodal 2-bit BHT feeding fetch prediction.
// Optional BHT_STATS_EN adds update/mispredict counters with stats_clr.
module branch_resolve_bht #(
  parameter int         XLEN        = 32,
  parameter int         BHT_ENTRIES = 64,
  parameter logic [1:0] CTR_INIT    = 2'b01
) (
  input  logic               clk,
  input  logic               rst,
`ifdef BHT_STATS_EN
  input  logic               stats_clr,
  output logic [31:0]        br_count,
  output logic [31:0]        mis_count,
`endif
  branch_resolve_bht_if.slave br
);

  localparam int IDX_W =
    (BHT_ENTRIES > 1) ? $clog2(BHT_ENTRIES) : 1;

  logic [1:0] bht_q [BHT_ENTRIES];
  logic [1:0] bht_d [BHT_ENTRIES];

  logic [IDX_W-1:0] idx_fetch;
  logic [IDX_W-1:0] idx_exe;
  logic             act;
  logic             is_jump;
  logic             is_branch;
  logic             eq;
  logic             lt_s;
  logic             lt_u;
  logic             taken_cond;
  logic             ill_f3;
  logic             pc_src_raw;
  logic             mis_raw;
  logic             upd;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_nxt;
  logic [XLEN-1:0]  pc_plus4;
  logic             unused_fetch_bits;

  assign idx_fetch = br.pc_fetch[IDX_W+1:2];
  assign idx_exe   = br.pc_exe[IDX_W+1:2];
  assign unused_fetch_bits =
    ^{br.pc_fetch[XLEN-1:IDX_W+2], br.pc_fetch[1:0]};

  assign act       = br.valid_exe & ~rst;
  assign is_jump   = act & br.jump_exe;
  assign is_branch = act & br.branch_exe & ~br.jump_exe;
  assign pc_plus4  = br.pc_exe + XLEN'(4);

  assign eq   = (br.rs1_exe == br.rs2_exe);
  assign lt_s = ($signed(br.rs1_exe) < $signed(br.rs2_exe));
  assign lt_u = (br.rs1_exe < br.rs2_exe);

  always_comb begin
    taken_cond = 1'b0;
    ill_f3     = 1'b0;
    case (br.funct3_exe)
      3'b000:  taken_cond = eq;
      3'b001:  taken_cond = ~eq;
      3'b100:  taken_cond = lt_s;
      3'b101:  taken_cond = ~lt_s;
      3'b110:  taken_cond = lt_u;
      3'b111:  taken_cond = ~lt_u;
      default: ill_f3     = 1'b1;
    endcase
  end

  assign br.illegal_br_exe = act & br.branch_exe & ill_f3;

  always_comb begin
    pc_src_raw         = 1'b0;
    mis_raw            = 1'b0;
    br.redirect_pc_exe = pc_plus4;
    unique case (1'b1)
      is_jump: begin
        pc_src_raw         = 1'b1;
        br.redirect_pc_exe = br.target_exe;
      end
      is_branch: begin
        mis_raw    = taken_cond ^ br.pred_taken_exe;
        pc_src_raw = mis_raw;
        if (taken_cond) begin
          br.redirect_pc_exe = br.target_exe;
        end
      end
      default: ;
    endcase
  end

  // case matches only a clean 1, so X/Z on the raw select resolves to 0
  always_comb begin
    case (pc_src_raw)
      1'b1:    br.pc_src_exe = 1'b1;
      default: br.pc_src_exe = 1'b0;
    endcase
    case (mis_raw)
      1'b1:    br.mispredict_exe = 1'b1;
      default: br.mispredict_exe = 1'b0;
    endcase
  end

  assign br.pred_taken_fetch =
    rst ? CTR_INIT[1] : bht_q[idx_fetch][1];

  assign upd = is_branch & ~br.stall_exe & ~ill_f3;
  assign ctr_cur = bht_q[idx_exe];

  always_comb begin
    ctr_nxt = ctr_cur;
    if (taken_cond) begin
      if (ctr_cur != 2'b11) ctr_nxt = ctr_cur + 2'b01;
    end else begin
      if (ctr_cur != 2'b00) ctr_nxt = ctr_cur - 2'b01;
    end
  end

  always_comb begin
    bht_d = bht_q;
    if (upd) begin
      bht_d[idx_exe] = ctr_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht_q[i] <= CTR_INIT;
      end
    end else begin
      bht_q <= bht_d;
    end
  end

`ifdef BHT_STATS_EN
  logic [31:0] br_count_q;
  logic [31:0] br_count_d;
  logic [31:0] mis_count_q;
  logic [31:0] mis_count_d;

  always_comb begin
    br_count_d  = br_count_q;
    mis_count_d = mis_count_q;
    if (stats_clr) begin
      br_count_d  = '0;
      mis_count_d = '0;
    end else if (upd) begin
      br_count_d = br_count_q + 32'd1;
      if (br.mispredict_exe) begin
        mis_count_d = mis_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      br_count_q  <= '0;
      mis_count_q <= '0;
    end else begin
      br_count_q  <= br_count_d;
      mis_count_q <= mis_count_d;
    end
  end

  assign br_count  = br_count_q;
  assign mis_count = mis_count_q;
`endif

endmodule

// File: tb/tb_branch_resolve_bht.sv
// Self-checking bench for branch_resolve_bht: vector table plus
// hand sequences, expected results queued at drive and popped at sample.
module tb_branch_resolve_bht;

  logic clk = 1'b0;
  logic rst;
  logic sclr = 1'b0;

  always #5 clk = ~clk;

  branch_resolve_bht_if bif();

`ifdef BHT_STATS_EN
  logic        stats_clr;
  logic [31:0] br_count;
  logic [31:0] mis_count;
  assign stats_clr = sclr;
`endif

  branch_resolve_bht dut (
    .clk       (clk),
    .rst       (rst),
`ifdef BHT_STATS_EN
    .stats_clr (stats_clr),
    .br_count  (br_count),
    .mis_count (mis_count),
`endif
    .br        (bif)
  );

  typedef struct {
    logic        valid, stall, branch, jump;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, tgt, fpc;
    logic        pred;
    logic        e_tk, e_src, e_mis, e_ill;
    logic [31:0] e_red;
  } vec_t;

  vec_t        sb_q[$];
  vec_t        tbl[$];
  logic [1:0]  mdl [64];
  int unsigned br_m = 0;
  int unsigned mis_m = 0;
  int          checks = 0;
  int          failures = 0;

  task automatic chk(string name, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t tv(
    logic v, logic s, logic b, logic j, logic [2:0] f3,
    logic [31:0] a, logic [31:0] c, logic [31:0] pc,
    logic p, logic tk, logic src, logic mis, logic ill,
    logic [31:0] red);
    vec_t r;
    r.valid = v; r.stall = s; r.branch = b; r.jump = j;
    r.f3 = f3; r.rs1 = a; r.rs2 = c; r.pc = pc;
    r.tgt = 32'h500; r.fpc = pc; r.pred = p;
    r.e_tk = tk; r.e_src = src; r.e_mis = mis;
    r.e_ill = ill; r.e_red = red;
    return r;
  endfunction

  // reference outcome built straight from the branch definitions
  function automatic vec_t mk(
    logic v, logic s, logic b, logic j, logic [2:0] f3,
    logic [31:0] a, logic [31:0] c, logic [31:0] pc,
    logic [31:0] tgt, logic p);
    vec_t r;
    logic tk;
    logic on;
    case (f3)
      3'd0: tk = (a == c);
      3'd1: tk = (a != c);
      3'd4: tk = ($signed(a) < $signed(c));
      3'd5: tk = !($signed(a) < $signed(c));
      3'd6: tk = (a < c);
      3'd7: tk = !(a < c);
      default: tk = 1'b0;
    endcase
    on = v & ~rst;
    r.valid = v; r.stall = s; r.branch = b; r.jump = j;
    r.f3 = f3; r.rs1 = a; r.rs2 = c; r.pc = pc;
    r.tgt = tgt; r.fpc = pc; r.pred = p; r.e_tk = tk;
    r.e_ill = on & b & (f3 == 3'd2 || f3 == 3'd3);
    r.e_src = 1'b0; r.e_mis = 1'b0; r.e_red = pc + 32'd4;
    if (on && j) begin
      r.e_src = 1'b1; r.e_red = tgt;
    end else if (on && b) begin
      r.e_mis = tk ^ p; r.e_src = tk ^ p;
      if (tk) r.e_red = tgt;
    end
    return r;
  endfunction

  task automatic run_vec(vec_t v);
    vec_t e;
    logic upd;
    int   fi;
    int   ei;
    bif.valid_exe      = v.valid;
    bif.stall_exe      = v.stall;
    bif.branch_exe     = v.branch;
    bif.jump_exe       = v.jump;
    bif.funct3_exe     = v.f3;
    bif.rs1_exe        = v.rs1;
    bif.rs2_exe        = v.rs2;
    bif.pc_exe         = v.pc;
    bif.target_exe     = v.tgt;
    bif.pred_taken_exe = v.pred;
    bif.pc_fetch       = v.fpc;
    sb_q.push_back(v);
    @(negedge clk);
    e = sb_q.pop_front();
    fi = int'(e.fpc[7:2]);
    chk("pc_src", {31'd0, bif.pc_src_exe}, {31'd0, e.e_src});
    chk("mispredict", {31'd0, bif.mispredict_exe},
        {31'd0, e.e_mis});
    chk("illegal", {31'd0, bif.illegal_br_exe},
        {31'd0, e.e_ill});
    chk("redirect", bif.redirect_pc_exe, e.e_red);
    chk("pred_fetch", {31'd0, bif.pred_taken_fetch},
        {31'd0, rst ? 1'b0 : mdl[fi][1]});
`ifdef BHT_STATS_EN
    chk("br_count", br_count, br_m);
    chk("mis_count", mis_count, mis_m);
`endif
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 64; i++) mdl[i] = 2'b01;
      br_m = 0;
      mis_m = 0;
    end else begin
      upd = e.valid & e.branch & ~e.jump & ~e.stall &
            ~(e.f3 == 3'd2 || e.f3 == 3'd3);
      ei = int'(e.pc[7:2]);
      if (upd) begin
        if (e.e_tk && mdl[ei] != 2'b11) mdl[ei] = mdl[ei] + 2'b01;
        if (!e.e_tk && mdl[ei] != 2'b00) mdl[ei] = mdl[ei] - 2'b01;
      end
      if (sclr) begin
        br_m = 0;
        mis_m = 0;
      end else if (upd) begin
        br_m++;
        if (e.e_mis) mis_m++;
      end
    end
    #1;
  endtask

  task automatic idle(logic [31:0] fpc);
    bif.valid_exe = 1'b0;
    bif.pc_fetch  = fpc;
    @(negedge clk);
    chk("pred_idle", {31'd0, bif.pred_taken_fetch},
        {31'd0, mdl[int'(fpc[7:2])][1]});
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mdl[i] = 2'b01;
    tbl.push_back(tv(1,0,1,0,0,5,5,32'h3c8,0, 1,1,1,0,32'h500));
    tbl.push_back(tv(1,0,1,0,0,5,6,32'h3c8,0, 0,0,0,0,32'h3cc));
    tbl.push_back(tv(1,0,1,0,1,5,6,32'h3c8,1, 1,0,0,0,32'h500));
    tbl.push_back(tv(1,0,1,0,4,32'hffffffff,1,32'h3c8,0,
                     1,1,1,0,32'h500));
    tbl.push_back(tv(1,0,1,0,6,32'hffffffff,1,32'h3c8,1,
                     0,1,1,0,32'h3cc));
    tbl.push_back(tv(1,0,1,0,5,1,32'hffffffff,32'h3c8,0,
                     1,1,1,0,32'h500));
    tbl.push_back(tv(1,0,1,0,5,7,7,32'h3c8,1, 1,0,0,0,32'h500));
    tbl.push_back(tv(1,0,1,0,7,1,32'hffffffff,32'h3c8,1,
                     0,1,1,0,32'h3cc));
    tbl.push_back(tv(1,0,1,0,6,1,2,32'h3c8,1, 1,0,0,0,32'h500));
    tbl.push_back(tv(1,0,1,0,4,1,32'hffffffff,32'h3c8,1,
                     0,1,1,0,32'h3cc));
    tbl.push_back(tv(1,0,1,0,2,5,5,32'h3c8,0, 0,0,0,1,32'h3cc));
    tbl.push_back(tv(1,0,1,0,3,5,5,32'h3c8,1, 0,1,1,1,32'h3cc));
    tbl.push_back(tv(1,0,1,1,0,5,5,32'h3c8,1, 1,1,0,0,32'h500));
    tbl.push_back(tv(0,0,0,1,0,5,5,32'h3c8,1, 1,0,0,0,32'h3cc));
    tbl.push_back(tv(0,0,1,0,0,5,5,32'h3c8,0, 1,0,0,0,32'h3cc));
    tbl.push_back(tv(1,0,0,1,2,5,5,32'h3c8,0, 0,1,0,0,32'h500));
    tbl.push_back(tv(1,1,1,0,0,5,6,32'hfffffffc,1,
                     0,1,1,0,32'h0));
    tbl.push_back(tv(1,1,1,0,6,1,2,32'h3c8,0, 1,1,1,0,32'h500));
    tbl.push_back(tv(1,0,1,0,7,32'hffffffff,32'hffffffff,
                     32'h3c8,0, 1,1,1,0,32'h500));
    tbl.push_back(tv(1,0,1,0,1,8,8,32'h3c8,1, 0,1,1,0,32'h3cc));

    rst = 1'b1;
    bif.valid_exe = 1'b0;
    bif.pc_fetch  = 32'h100;
    @(posedge clk);
    #1;
    run_vec(mk(1,0,1,0,0,5,5,32'h100,32'h200,0));
    run_vec(mk(1,0,1,1,0,5,5,32'h100,32'h200,0));
    rst = 1'b0;

    run_vec(mk(1,0,1,0,0,5,5,32'h100,32'h200,0));
    for (int i = 0; i < 64; i++) idle(32'(i * 4 + 32'h100));

    for (int k = 0; k < 4; k++)
      run_vec(mk(1,0,1,0,1,3,4,32'h180,32'h280,k > 1));
    run_vec(mk(1,0,1,0,1,3,3,32'h180,32'h280,1));
    idle(32'h180);
    idle(32'h184);
    run_vec(mk(1,0,1,0,1,3,3,32'h180,32'h280,1));
    idle(32'h180);

    for (int k = 0; k < 3; k++)
      run_vec(mk(1,1,1,0,0,5,5,32'h1c0,32'h220,0));
    run_vec(mk(1,0,1,0,0,5,5,32'h1c0,32'h220,0));
    idle(32'h1c0);
    run_vec(mk(1,0,1,0,0,5,6,32'h1c0,32'h220,1));
    idle(32'h1c0);

    run_vec(mk(1,0,1,0,2,5,5,32'h240,32'h300,0));
    run_vec(mk(1,0,1,0,0,5,5,32'h240,32'h300,0));
    idle(32'h240);

    run_vec(mk(1,0,1,1,0,5,5,32'h108,32'h400,0));
    run_vec(mk(0,0,1,1,0,5,5,32'h108,32'h400,0));
    idle(32'h108);

    foreach (tbl[i]) run_vec(tbl[i]);
    idle(32'h3c8);

    sclr = 1'b1;
    run_vec(mk(1,0,1,0,0,5,5,32'h100,32'h200,0));
    sclr = 1'b0;
    run_vec(mk(1,0,1,0,0,5,6,32'h100,32'h200,1));
    idle(32'h100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
